ctrl_if_axi4lite_initiator: RTL and testbench
=============================================

CTRL_IF_AXI4LITE_INITIATOR -- requirements
Module: ctrl_if_axi4lite_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256, read-timeout limit in clock cycles (used only when CTRL_IF_RD_TIMEOUT_EN is defined).
REQ-002 Ports SHALL be:
clock  in  1  clock; all logic on rising edge
resetn  in  1  reset, asynchronous, active-low
awvalid/awready  in/out  1/1  AXI4-Lite write-address handshake
awaddr  in  11  write byte address
wvalid/wready  in/out  1/1  write-data handshake
wdata  in  32  write data
wstrb  in  4  write byte strobes
bvalid/bready  out/in  1/1  write-response handshake
bresp  out  2  write response
arvalid/arready  in/out  1/1  read-address handshake
araddr  in  11  read byte address
rvalid/rready  out/in  1/1  read-data handshake
rdata  out  32  read data
rresp  out  2  read response
ctrlSel  out  1  register-bank select, one access per assertion
ctrlWr  out  1  1 = write, 0 = read
ctrlAddr  out  11  register address, word-aligned
ctrlWrData  out  32  write data
ctrlWrStrbs  out  4  byte strobes
ctrlRdData  in  32  read data from register bank
ctrlRdValid  in  1  ctrlRdData valid this cycle

Function
REQ-003 FSM states SHALL be IDLE, WRITE, WR_RESP, READ, RD_RESP; one transaction in flight at any time.
REQ-004 IDLE: write granted when awvalid&wvalid both high; read granted when arvalid high; awready=wready=1 (combinational) only in an IDLE cycle granting a write; arready=1 only in an IDLE cycle granting a read.
REQ-005 Simultaneous write and read request SHALL be round-robin: the type not served most recently wins; write wins the first tie after reset.
REQ-006 awvalid without wvalid (or vice versa) SHALL NOT be accepted; neither ready asserted.
REQ-007 On accept, address SHALL be registered as {addr[10:2],2'b00}; wdata/wstrb registered for writes.
REQ-008 WRITE: exactly one cycle with ctrlSel=1, ctrlWr=1, registered address/data/strobes on ctrl outputs; next state WR_RESP.
REQ-009 WR_RESP: bvalid=1, bresp=2'b00 held until bvalid&bready, then IDLE; earliest next accept is the following cycle.
REQ-010 READ: ctrlSel=1, ctrlWr=0, ctrlWrStrbs=4'b0 each cycle until ctrlRdValid=1; that cycle ctrlRdData SHALL be captured into rdata, rresp=2'b00, next state RD_RESP.
REQ-011 RD_RESP: rvalid=1, rdata/rresp stable until rvalid&rready, then IDLE.
REQ-012 ctrlSel SHALL be 0 in IDLE, WR_RESP, RD_RESP; ctrlAddr/ctrlWrData hold last driven value while ctrlSel=0.
REQ-013 Minimum latency: write accept to bvalid = 2 cycles; read accept to rvalid = 2 cycles with ctrlRdValid tied 1.
REQ-014 awaddr bits [1:0] and unaligned addresses SHALL be ignored, never produce an error.

Reset
REQ-015 resetn low SHALL force IDLE asynchronously, discarding any in-flight transaction without a response.
REQ-016 Reset values: all ready/valid outputs 0, ctrlSel 0, ctrlWr 0, ctrlAddr 0, ctrlWrData 0, ctrlWrStrbs 0, rdata 0, bresp 0, rresp 0, round-robin pointer "write next", timeout counter 0.

Configuration
REQ-017 Macro CTRL_IF_RD_TIMEOUT_EN defined: counter in READ increments each cycle without ctrlRdValid; after TIMEOUT_CYCLES such cycles, rdata=32'h0, rresp=2'b10 (SLVERR), next state RD_RESP; counter cleared on entering READ.
REQ-018 Macro undefined: no counter logic; READ waits indefinitely for ctrlRdValid; rresp always 2'b00.

Verification
REQ-019 Write awaddr=11'h004, wdata=32'h0000_000F, wstrb=4'hF -> one-cycle ctrlSel=ctrlWr=1, ctrlAddr=11'h004, ctrlWrData=32'h0000_000F; bvalid 2 cycles after accept, bresp=00.
REQ-020 Read araddr=11'h003, ctrlRdValid=1, ctrlRdData=32'h0001_0203 -> ctrlAddr=11'h000, rdata=32'h0001_0203, rresp=00; rready held 0 for 5 cycles -> rvalid/rdata stable throughout.
REQ-021 awvalid, wvalid, arvalid high together twice -> first write, then read; a third tie -> write.
REQ-022 Macro defined, TIMEOUT_CYCLES=8, ctrlRdValid=0 -> rvalid after 8 READ cycles, rdata=0, rresp=10; macro undefined -> no rvalid after 1000 cycles.
REQ-023 resetn pulsed low during READ and during WR_RESP -> all outputs at reset values immediately; next read accepted and completes normally.

Source files
------------

// File: rtl/ctrl_if_axi4lite_initiator.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_if_axi4lite_initiator
// Description : AXI4-Lite slave port that turns each accepted write or read
//               into a single access on a simple register-bank control bus
//               (ctrlSel/ctrlWr/ctrlAddr/...). One transaction in flight.
//               Optional read timeout: define CTRL_IF_RD_TIMEOUT_EN to make a
//               read that never sees ctrlRdValid end with SLVERR after
//               TIMEOUT_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_if_axi4lite_initiator #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        resetn,
  // write address / data / response
  input  logic        awvalid,
  output logic        awready,
  input  logic [10:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  // read address / data
  input  logic        arvalid,
  output logic        arready,
  input  logic [10:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  // register-bank side
  output logic        ctrlSel,
  output logic        ctrlWr,
  output logic [10:0] ctrlAddr,
  output logic [31:0] ctrlWrData,
  output logic [3:0]  ctrlWrStrbs,
  input  logic [31:0] ctrlRdData,
  input  logic        ctrlRdValid
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    WR_RESP = 3'd2,
    READ    = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t r_state;
  // Round-robin pointer: 1 means a write wins the next write/read tie.
  logic   r_wrNext;

  logic   w_wrReq;
  logic   w_grantWr;
  logic   w_grantRd;
  // Byte-lane address bits are deliberately dropped; registers are word wide.
  logic   w_unusedAddrLsbs;

`ifdef CTRL_IF_RD_TIMEOUT_EN
  localparam int                 c_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  logic [c_CNT_W-1:0] r_toCnt;
`endif

  // A timeout of zero cycles has no meaning; reject it at elaboration.
  if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign w_unusedAddrLsbs = ^{awaddr[1:0], araddr[1:0]};

  // A write needs both address and data present; the pointer breaks ties.
  assign w_wrReq   = awvalid & wvalid;
  assign w_grantWr = (r_state == IDLE) & w_wrReq & (~arvalid | r_wrNext);
  assign w_grantRd = (r_state == IDLE) & arvalid & (~w_wrReq | ~r_wrNext);

  // Readies are pure grant indications so address and data are taken together.
  assign awready = w_grantWr;
  assign wready  = w_grantWr;
  assign arready = w_grantRd;

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_wrNext    <= 1'b1;
      bvalid      <= 1'b0;
      bresp       <= 2'b00;
      rvalid      <= 1'b0;
      rdata       <= 32'h0;
      rresp       <= 2'b00;
      ctrlSel     <= 1'b0;
      ctrlWr      <= 1'b0;
      ctrlAddr    <= 11'h0;
      ctrlWrData  <= 32'h0;
      ctrlWrStrbs <= 4'h0;
`ifdef CTRL_IF_RD_TIMEOUT_EN
      r_toCnt     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantWr) begin
            r_state     <= WRITE;
            r_wrNext    <= 1'b0;
            ctrlSel     <= 1'b1;
            ctrlWr      <= 1'b1;
            ctrlAddr    <= {awaddr[10:2], 2'b00};
            ctrlWrData  <= wdata;
            ctrlWrStrbs <= wstrb;
          end else if (w_grantRd) begin
            r_state     <= READ;
            r_wrNext    <= 1'b1;
            ctrlSel     <= 1'b1;
            ctrlWr      <= 1'b0;
            ctrlAddr    <= {araddr[10:2], 2'b00};
            ctrlWrStrbs <= 4'h0;
`ifdef CTRL_IF_RD_TIMEOUT_EN
            r_toCnt     <= '0;
`endif
          end
        end
        WRITE: begin
          // The register bank takes the write in this single selected cycle.
          ctrlSel     <= 1'b0;
          ctrlWr      <= 1'b0;
          ctrlWrStrbs <= 4'h0;
          bvalid      <= 1'b1;
          bresp       <= 2'b00;
          r_state     <= WR_RESP;
        end
        WR_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            r_state <= IDLE;
          end
        end
        READ: begin
          if (ctrlRdValid) begin
            ctrlSel <= 1'b0;
            rdata   <= ctrlRdData;
            rresp   <= 2'b00;
            rvalid  <= 1'b1;
            r_state <= RD_RESP;
          end
`ifdef CTRL_IF_RD_TIMEOUT_EN
          else if (r_toCnt == c_TO_LAST) begin
            ctrlSel <= 1'b0;
            rdata   <= 32'h0;
            rresp   <= 2'b10;
            rvalid  <= 1'b1;
            r_state <= RD_RESP;
          end else begin
            r_toCnt <= r_toCnt + c_CNT_ONE;
          end
`endif
        end
        RD_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_if_axi4lite_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_if_axi4lite_initiator
// Description : Directed bench for ctrl_if_axi4lite_initiator. Expected bus
//               accesses and responses are queued when a request is driven and
//               popped when the DUT produces them. Honours
//               CTRL_IF_RD_TIMEOUT_EN for the read-timeout case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_if_axi4lite_initiator;

  localparam int TO = 8;

  logic        clock;
  logic        resetn;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [10:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic        ctrlSel, ctrlWr, ctrlRdValid;
  logic [10:0] ctrlAddr;
  logic [31:0] ctrlWrData, ctrlRdData;
  logic [3:0]  ctrlWrStrbs;

  typedef struct {
    logic        isWr;
    logic [10:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ctrlExp_t;

  typedef struct {
    logic        isWr;
    logic [31:0] data;
    logic [1:0]  resp;
  } respExp_t;

  ctrlExp_t ctrlQ[$];
  respExp_t respQ[$];

  int passCnt  = 0;
  int failCnt  = 0;
  int totalCnt = 0;
  int cyc      = 0;
  int accCyc   = 0;

  ctrl_if_axi4lite_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .resetn(resetn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .ctrlSel(ctrlSel), .ctrlWr(ctrlWr), .ctrlAddr(ctrlAddr),
    .ctrlWrData(ctrlWrData), .ctrlWrStrbs(ctrlWrStrbs),
    .ctrlRdData(ctrlRdData), .ctrlRdValid(ctrlRdValid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Free-running cycle number used to measure accept-to-response latency.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chkResetOuts(input string tag);
    chk({tag, "_ctl"}, {awready, wready, bvalid, bresp, arready, rvalid, rresp,
                        ctrlSel, ctrlWr, ctrlWrStrbs, ctrlAddr}, 64'h0);
    chk({tag, "_rdata"}, rdata, 64'h0);
    chk({tag, "_wrdata"}, ctrlWrData, 64'h0);
  endtask

  task automatic driveWrite(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d; wstrb = s;
  endtask

  task automatic driveRead(input logic [10:0] a, input logic [31:0] bank);
    arvalid = 1'b1; araddr = a; ctrlRdData = bank;
  endtask

  task automatic expectWrite(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
    ctrlQ.push_back('{1'b1, {a[10:2], 2'b00}, d, s});
    respQ.push_back('{1'b1, 32'h0, 2'b00});
  endtask

  task automatic expectRead(input logic [10:0] a, input logic [31:0] d, input logic [1:0] r);
    ctrlQ.push_back('{1'b0, {a[10:2], 2'b00}, 32'h0, 4'h0});
    respQ.push_back('{1'b0, d, r});
  endtask

  // Waits for the expected ready, checks the other ready stays low, then
  // lets the accepting edge pass and withdraws every request.
  task automatic waitAccept(input bit isWr);
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (isWr ? (awready && wready) : arready) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk(isWr ? "accept_wr" : "accept_rd", got, 1);
    if (got) begin
      chk("other_ready_low", isWr ? arready : (awready | wready), 0);
      accCyc = cyc;
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
  endtask

  task automatic waitCtrl(input int expSel, input int releaseAt);
    ctrlExp_t e;
    bit got = 1'b0;
    int n = 0;
    for (int i = 0; i < 20; i++) begin
      if (ctrlSel) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("ctrlSel_seen", got, 1);
    if (!got || ctrlQ.size() == 0) return;
    e = ctrlQ.pop_front();
    chk("ctrlWr", ctrlWr, e.isWr);
    chk("ctrlAddr", ctrlAddr, e.addr);
    chk("ctrlWrStrbs", ctrlWrStrbs, e.strb);
    if (e.isWr) chk("ctrlWrData", ctrlWrData, e.data);
    while (ctrlSel && n < 100) begin
      n++;
      if (n == releaseAt) ctrlRdValid = 1'b1;
      tick();
    end
    chk("ctrlSel_cycles", n, expSel);
    chk("ctrlAddr_hold", ctrlAddr, e.addr);
  endtask

  task automatic waitResp(input int expLat, input int hold);
    respExp_t e;
    bit got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bvalid || rvalid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("resp_seen", got, 1);
    if (!got || respQ.size() == 0) return;
    e = respQ.pop_front();
    chk("resp_latency", cyc - accCyc, expLat);
    if (e.isWr) begin
      chk("bvalid", {bvalid, rvalid}, 2'b10);
      chk("bresp", bresp, e.resp);
    end else begin
      chk("rvalid", {bvalid, rvalid}, 2'b01);
      chk("rdata", rdata, e.data);
      chk("rresp", rresp, e.resp);
    end
    // Disturb the bank data: a captured response must not follow it.
    ctrlRdData = 32'hDEAD_BEEF;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (e.isWr) chk("bvalid_hold", {bvalid, bresp}, {1'b1, e.resp});
      else        chk("rvalid_hold", {rvalid, rresp, rdata}, {1'b1, e.resp, e.data});
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    chk("valid_drop", {bvalid, rvalid}, 2'b00);
    bready = 1'b0; rready = 1'b0;
  endtask

  task automatic pulseReset();
    resetn = 1'b0;
    #1;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    bready = 1'b0; rready = 1'b0;
    ctrlRdData = '0; ctrlRdValid = 1'b1;

    repeat (2) tick();
    chkResetOuts("reset");
    resetn = 1'b1;
    tick();

    // Half a write request is never accepted.
    awvalid = 1'b1; awaddr = 11'h004;
    #1;
    chk("aw_only_ready", {awready, wready}, 2'b00);
    tick();
    chk("aw_only_sel", ctrlSel, 0);
    awvalid = 1'b0; wvalid = 1'b1;
    #1;
    chk("w_only_ready", {awready, wready}, 2'b00);
    tick();
    wvalid = 1'b0;
    tick();

    // Basic write.
    expectWrite(11'h004, 32'h0000_000F, 4'hF);
    driveWrite(11'h004, 32'h0000_000F, 4'hF);
    waitAccept(1'b1);
    waitCtrl(1, 0);
    waitResp(2, 0);

    // Unaligned read, response held off for five cycles.
    ctrlRdValid = 1'b1;
    expectRead(11'h003, 32'h0001_0203, 2'b00);
    driveRead(11'h003, 32'h0001_0203);
    waitAccept(1'b0);
    waitCtrl(1, 0);
    waitResp(2, 5);

    // Top of the address space, partial strobes, response held off.
    expectWrite(11'h7FF, 32'hA5A5_5A5A, 4'h5);
    driveWrite(11'h7FF, 32'hA5A5_5A5A, 4'h5);
    waitAccept(1'b1);
    waitCtrl(1, 0);
    waitResp(2, 3);

    // Read whose bank data arrives in the fourth selected cycle.
    ctrlRdValid = 1'b0;
    expectRead(11'h2A6, 32'hCAFE_0042, 2'b00);
    driveRead(11'h2A6, 32'hCAFE_0042);
    waitAccept(1'b0);
    waitCtrl(4, 4);
    waitResp(5, 0);

    // Ties after reset: write, then read, then write.
    pulseReset();
    ctrlRdValid = 1'b1;
    expectWrite(11'h010, 32'h1111_1111, 4'hF);
    driveWrite(11'h010, 32'h1111_1111, 4'hF);
    driveRead(11'h020, 32'h2222_2222);
    waitAccept(1'b1);
    waitCtrl(1, 0);
    waitResp(2, 0);
    expectRead(11'h020, 32'h2222_2222, 2'b00);
    driveWrite(11'h014, 32'h3333_3333, 4'hF);
    driveRead(11'h020, 32'h2222_2222);
    waitAccept(1'b0);
    waitCtrl(1, 0);
    waitResp(2, 0);
    expectWrite(11'h018, 32'h4444_4444, 4'h3);
    driveWrite(11'h018, 32'h4444_4444, 4'h3);
    driveRead(11'h024, 32'h5555_5555);
    waitAccept(1'b1);
    waitCtrl(1, 0);
    waitResp(2, 0);

    // Reset while a write response is pending, then a normal read.
    expectWrite(11'h030, 32'h6666_6666, 4'hF);
    driveWrite(11'h030, 32'h6666_6666, 4'hF);
    waitAccept(1'b1);
    waitCtrl(1, 0);
    chk("wr_resp_pending", bvalid, 1);
    resetn = 1'b0;
    #1;
    chkResetOuts("rst_wrresp");
    respQ.delete();
    tick();
    resetn = 1'b1;
    tick();
    ctrlRdValid = 1'b1;
    expectRead(11'h10C, 32'h0000_1234, 2'b00);
    driveRead(11'h10C, 32'h0000_1234);
    waitAccept(1'b0);
    waitCtrl(1, 0);
    waitResp(2, 0);

    // Reset while a read is waiting on the bank, then a normal read.
    ctrlRdValid = 1'b0;
    driveRead(11'h040, 32'h7777_7777);
    waitAccept(1'b0);
    tick();
    chk("read_in_flight", ctrlSel, 1);
    resetn = 1'b0;
    #1;
    chkResetOuts("rst_read");
    tick();
    resetn = 1'b1;
    tick();
    ctrlRdValid = 1'b1;
    expectRead(11'h044, 32'h8888_0001, 2'b00);
    driveRead(11'h044, 32'h8888_0001);
    waitAccept(1'b0);
    waitCtrl(1, 0);
    waitResp(2, 0);

    // Read that the bank never answers.
    ctrlRdValid = 1'b0;
`ifdef CTRL_IF_RD_TIMEOUT_EN
    expectRead(11'h050, 32'h0, 2'b10);
    driveRead(11'h050, 32'hBAD0_0BAD);
    waitAccept(1'b0);
    waitCtrl(TO, 0);
    waitResp(TO + 1, 2);
`else
    begin
      bit seen = 1'b0;
      driveRead(11'h050, 32'hBAD0_0BAD);
      waitAccept(1'b0);
      for (int i = 0; i < 1000; i++) begin
        if (rvalid) seen = 1'b1;
        tick();
      end
      chk("no_rvalid_1000", seen, 0);
      chk("still_reading", ctrlSel, 1);
      pulseReset();
    end
`endif

    chk("ctrlQ_empty", ctrlQ.size(), 0);
    chk("respQ_empty", respQ.size(), 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
`default_nettype wire
